adc_scan_sequencer: RTL

//  Sequences the serial ADC front-end through a periodic round-robin channel scan.

---
 rtl/adc_pkg.sv | 17 +
 rtl/adc_ch_store.sv | 44 ++++
 rtl/adc_scan_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC scan sequencer.
package adc_pkg;

  localparam int ADC_DATA_W  = 8;
  localparam int DEF_PERIOD  = 1000;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_CONV,
    S_STORE,
    S_NEXT
  } scan_state_t;

endpackage

// File: rtl/adc_ch_store.sv
// Per-channel result RAM with hysteresis alarm LEDs; combinational readback.
module adc_ch_store #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8,
  parameter int CH_W   = 1
) (
  input  logic              clk,
  input  logic              rstc,
  input  logic              we,
  input  logic [CH_W-1:0]   ch,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] thr_hi,
  input  logic [DATA_W-1:0] thr_lo,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic [NUM_CH-1:0] led
);

  logic [NUM_CH-1:0][DATA_W-1:0] mem;

  // Set test first, so a misconfigured thr_lo > thr_hi resolves toward "on".
  always_ff @(posedge clk) begin
    if (rstc) begin
      mem <= '0;
      led <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch == CH_W'(i)) begin
          mem[i] <= data;
          if (data > thr_hi)      led[i] <= 1'b1;
          else if (data < thr_lo) led[i] <= 1'b0;
        end
      end
    end
  end

  // Channels outside the populated range read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_ch == CH_W'(i)) rd_data = mem[i];
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Periodic round-robin ADC scan: start, capture, store, alarm, with conversion timeout.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = ADC_DATA_W,
  parameter int PERIOD  = DEF_PERIOD,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rstc,
  input  logic              enable,
  input  logic [DATA_W-1:0] thr_hi,
  input  logic [DATA_W-1:0] thr_lo,
  output logic              adc_start,
  output logic [CH_W-1:0]   adc_ch,
  input  logic              adc_busy,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              sample_vld,
  output logic [CH_W-1:0]   sample_ch,
  output logic [NUM_CH-1:0] led,
  output logic              timeout_err
);

  localparam int PW = $clog2(PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  scan_state_t       state, state_nx;
  logic [PW-1:0]     per_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic [CH_W-1:0]   ptr;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              per_tc, tmo_tc;

  assign per_tc = (per_cnt == PW'(PERIOD - 1));
  assign tmo_tc = (tmo_cnt == TW'(TIMEOUT));

  // The period count runs from each start through CONV/STORE/NEXT so that
  // start-to-start spacing is exactly PERIOD regardless of conversion length.
  always_ff @(posedge clk) begin
    if (rstc) begin
      state   <= S_IDLE;
      per_cnt <= '0;
      tmo_cnt <= '0;
      ptr     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE:  per_cnt <= '0;
        S_START: begin
          per_cnt <= PW'(1);
          tmo_cnt <= TW'(1);
        end
        default: if (!per_tc) per_cnt <= per_cnt + 1'b1;
      endcase
      if (state == S_CONV) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (adc_done)    data_q <= adc_data;
        else if (tmo_tc) err_q  <= 1'b1;
      end
      if (state == S_NEXT)
        ptr <= (ptr == CH_W'(NUM_CH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    adc_start  = 1'b0;
    sample_vld = 1'b0;
    case (state)
      S_IDLE:  if (enable) state_nx = S_WAIT;
      S_WAIT: begin
        if (!enable)                  state_nx = S_IDLE;
        else if (per_tc && !adc_busy) state_nx = S_START;
      end
      S_START: begin
        adc_start = 1'b1;
        state_nx  = S_CONV;
      end
      S_CONV: begin
        // done beats a coincident timeout
        if (adc_done)    state_nx = S_STORE;
        else if (tmo_tc) state_nx = S_NEXT;
      end
      S_STORE: begin
        sample_vld = 1'b1;
        state_nx   = S_NEXT;
      end
      S_NEXT:  state_nx = enable ? S_WAIT : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign adc_ch      = ptr;
  assign sample_ch   = ptr;
  assign timeout_err = err_q;

  adc_ch_store #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .CH_W   (CH_W)
  ) u_store (
    .clk     (clk),
    .rstc    (rstc),
    .we      (state == S_STORE),
    .ch      (ptr),
    .data    (data_q),
    .thr_hi  (thr_hi),
    .thr_lo  (thr_lo),
    .rd_ch   (rd_ch),
    .rd_data (rd_data),
    .led     (led)
  );

endmodule
